// File: rtl/rle_coeff_decoder.sv
// Run-length coefficient decoder: turns Huffman-decoded (RRRR,SSSS)+amplitude
// symbols into (run, value) beats for the zigzag stage, with DC prediction.
module rle_coeff_decoder (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [7:0]  symbol_in,
  input  logic [10:0] amp_in,
  input  logic [1:0]  comp_in,
  input  logic        valid_in,
  input  logic        restart_in,
  output logic [11:0] value_out,
  output logic [5:0]  run_out,
  output logic        valid_out,
  output logic        block_done_out,
  output logic        error_out
);

  typedef enum logic {EXPECT_DC, EXPECT_AC} state_t;

  state_t      state_reg, state_next;
  logic [6:0]  pos_reg, pos_next;
  logic [11:0] value_reg, value_next;
  logic [5:0]  run_reg, run_next;
  logic        valid_reg, valid_next;
  logic        done_reg, done_next;
  logic        error_reg, error_next;
  logic [11:0] pred_reg [0:2];
  logic        pred_we, pred_clr;

  logic [3:0]  rrrr, ssss;
  logic [11:0] amp_mask, amp_bits, ext, pred_sel, dc_sum;
  logic        sign_set, dc_illegal;
  logic        is_eob, is_zrl, ac_illegal;
  logic [6:0]  ac_pos;
  logic [5:0]  ac_run;

  assign rrrr = symbol_in[7:4];
  assign ssss = symbol_in[3:0];

  // Top bit of the size field set means positive; otherwise the value is
  // amp - (2^S - 1), the usual one's-complement-style negative encoding.
  always_comb begin
    amp_mask = (12'd1 << ssss) - 12'd1;
    amp_bits = {1'b0, amp_in} & amp_mask;
    sign_set = |(amp_bits & ~(amp_mask >> 1));
    if (ssss == 4'd0)
      ext = 12'd0;
    else if (sign_set)
      ext = amp_bits;
    else
      ext = amp_bits - amp_mask;
  end

  always_comb begin
    case (comp_in)
      2'd0:    pred_sel = pred_reg[0];
      2'd1:    pred_sel = pred_reg[1];
      2'd2:    pred_sel = pred_reg[2];
      default: pred_sel = pred_reg[0];
    endcase
  end

  assign dc_sum     = pred_sel + ext;
  assign dc_illegal = (ssss > 4'd11) || (comp_in == 2'd3);

  // ZRL has RRRR=15, so pos+RRRR+1 already yields the +16 advance.
  always_comb begin
    is_eob = (symbol_in == 8'h00);
    is_zrl = (symbol_in == 8'hF0);
    if (is_eob) begin
      ac_pos = 7'd64;
      ac_run = 6'(7'd63 - pos_reg);
    end else begin
      ac_pos = pos_reg + 7'(rrrr) + 7'd1;
      ac_run = 6'(rrrr);
    end
    ac_illegal = (ssss > 4'd10) ||
                 ((ssss == 4'd0) && !is_eob && !is_zrl) ||
                 (ac_pos > 7'd64);
  end

  always_comb begin
    state_next = state_reg;
    pos_next   = pos_reg;
    value_next = value_reg;
    run_next   = run_reg;
    valid_next = 1'b0;
    done_next  = 1'b0;
    error_next = error_reg;
    pred_we    = 1'b0;
    pred_clr   = 1'b0;
    if (restart_in) begin
      state_next = EXPECT_DC;
      pos_next   = 7'd0;
      error_next = 1'b0;
      pred_clr   = 1'b1;
    end else if (valid_in) begin
      if (state_reg == EXPECT_DC) begin
        if (dc_illegal) begin
          error_next = 1'b1;
        end else begin
          valid_next = 1'b1;
          value_next = dc_sum;
          run_next   = 6'd0;
          pred_we    = 1'b1;
          pos_next   = 7'd1;
          state_next = EXPECT_AC;
        end
      end else begin
        if (ac_illegal) begin
          error_next = 1'b1;
        end else begin
          valid_next = 1'b1;
          value_next = ext;
          run_next   = ac_run;
          if (ac_pos == 7'd64) begin
            done_next  = 1'b1;
            pos_next   = 7'd0;
            state_next = EXPECT_DC;
          end else begin
            pos_next = ac_pos;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_reg <= EXPECT_DC;
      pos_reg   <= 7'd0;
      value_reg <= 12'd0;
      run_reg   <= 6'd0;
      valid_reg <= 1'b0;
      done_reg  <= 1'b0;
      error_reg <= 1'b0;
      for (int i = 0; i < 3; i++) pred_reg[i] <= 12'd0;
    end else begin
      state_reg <= state_next;
      pos_reg   <= pos_next;
      value_reg <= value_next;
      run_reg   <= run_next;
      valid_reg <= valid_next;
      done_reg  <= done_next;
      error_reg <= error_next;
      for (int i = 0; i < 3; i++) begin
        if (pred_clr)
          pred_reg[i] <= 12'd0;
        else if (pred_we && (comp_in == 2'(i)))
          pred_reg[i] <= dc_sum;
      end
    end
  end

  assign value_out      = value_reg;
  assign run_out        = run_reg;
  assign valid_out      = valid_reg;
  assign block_done_out = done_reg;
  assign error_out      = error_reg;

endmodule

// File: tb/tb_rle_coeff_decoder.sv
// Directed bench for rle_coeff_decoder with hand-computed expected beats.
module tb_rle_coeff_decoder;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic [7:0]  symbol_in = 8'h00;
  logic [10:0] amp_in = 11'd0;
  logic [1:0]  comp_in = 2'd0;
  logic        valid_in = 1'b0;
  logic        restart_in = 1'b0;
  logic [11:0] value_out;
  logic [5:0]  run_out;
  logic        valid_out;
  logic        block_done_out;
  logic        error_out;

  int n_checks = 0;
  int n_fail   = 0;

  rle_coeff_decoder dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .symbol_in(symbol_in), .amp_in(amp_in), .comp_in(comp_in),
    .valid_in(valid_in), .restart_in(restart_in),
    .value_out(value_out), .run_out(run_out), .valid_out(valid_out),
    .block_done_out(block_done_out), .error_out(error_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Present one symbol for one clock; outputs are sampled 1ns after the edge.
  task automatic send(input logic [7:0] s, input logic [10:0] a, input logic [1:0] c);
    symbol_in = s; amp_in = a; comp_in = c; valid_in = 1'b1;
    @(posedge clk_in); #1;
    valid_in = 1'b0;
    $display("sym=%02h amp=%03h comp=%0d -> valid=%0b value=%03h run=%0d done=%0b err=%0b",
             s, a, c, valid_out, value_out, run_out, block_done_out, error_out);
  endtask

  task automatic expect_beat(input string tag, input logic [11:0] v, input logic [5:0] r, input logic d);
    check_eq({tag, ".valid"}, 32'(valid_out), 32'd1);
    check_eq({tag, ".value"}, 32'(value_out), 32'(v));
    check_eq({tag, ".run"},   32'(run_out),   32'(r));
    check_eq({tag, ".done"},  32'(block_done_out), 32'(d));
  endtask

  task automatic expect_err(input string tag);
    check_eq({tag, ".valid"}, 32'(valid_out), 32'd0);
    check_eq({tag, ".err"},   32'(error_out), 32'd1);
  endtask

  task automatic pulse_restart(input logic with_symbol);
    restart_in = 1'b1;
    symbol_in = 8'h01; amp_in = 11'd1; comp_in = 2'd0; valid_in = with_symbol;
    @(posedge clk_in); #1;
    restart_in = 1'b0; valid_in = 1'b0;
    $display("restart (symbol=%0b) -> valid=%0b err=%0b", with_symbol, valid_out, error_out);
  endtask

  initial begin
    int beats, dones;
    logic last_done;

    #3;
    check_eq("rst.valid", 32'(valid_out), 32'd0);
    check_eq("rst.value", 32'(value_out), 32'd0);
    check_eq("rst.run",   32'(run_out),   32'd0);
    check_eq("rst.done",  32'(block_done_out), 32'd0);
    check_eq("rst.err",   32'(error_out), 32'd0);
    @(posedge clk_in); @(posedge clk_in); #1;
    rst_in = 1'b0;

    // DC path and second-block prediction
    send(8'h03, 11'b101, 2'd0); expect_beat("dc1", 12'd5, 6'd0, 1'b0);
    send(8'h00, 11'd0, 2'd0);   expect_beat("eob1", 12'd0, 6'd62, 1'b1);
    send(8'h02, 11'b01, 2'd0);  expect_beat("dc2", 12'd3, 6'd0, 1'b0);
    // Negative AC, pos 1 -> 4, then EOB run 59
    send(8'h23, 11'b010, 2'd0); expect_beat("ac_neg", 12'hFFB, 6'd2, 1'b0);
    send(8'h00, 11'd0, 2'd0);   expect_beat("eob2", 12'd0, 6'd59, 1'b1);
    // EOB at pos 2, following symbol must be DC
    send(8'h00, 11'd0, 2'd0);   expect_beat("dc3", 12'd3, 6'd0, 1'b0);
    send(8'h01, 11'd1, 2'd0);   expect_beat("ac1", 12'd1, 6'd0, 1'b0);
    send(8'h00, 11'd0, 2'd0);   expect_beat("eob3", 12'd0, 6'd61, 1'b1);
    send(8'h01, 11'd0, 2'd0);   expect_beat("dc4", 12'd2, 6'd0, 1'b0);

    // Full block of 63 AC beats after the DC above
    beats = 0; dones = 0; last_done = 1'b0;
    for (int i = 0; i < 63; i++) begin
      send(8'h01, 11'd1, 2'd0);
      if (valid_out && value_out == 12'd1 && run_out == 6'd0) beats++;
      if (block_done_out) dones++;
      if (i == 62) last_done = block_done_out;
    end
    check_eq("full.beats", 32'(beats), 32'd63);
    check_eq("full.dones", 32'(dones), 32'd1);
    check_eq("full.last",  32'(last_done), 32'd1);

    // ZRL x3 then an illegal AC size
    send(8'h00, 11'd0, 2'd0);   expect_beat("dc5", 12'd2, 6'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      send(8'hF0, 11'd0, 2'd0); expect_beat("zrl", 12'd0, 6'd15, 1'b0);
    end
    send(8'h0F, 11'd0, 2'd0);   expect_err("ac_s15");
    send(8'h00, 11'd0, 2'd0);   expect_beat("eob4", 12'd0, 6'd14, 1'b1);
    check_eq("err.sticky", 32'(error_out), 32'd1);

    // Restart wins over a simultaneous symbol and clears the error
    pulse_restart(1'b1);
    check_eq("rs.valid", 32'(valid_out), 32'd0);
    check_eq("rs.err",   32'(error_out), 32'd0);
    send(8'h00, 11'd0, 2'd0);   expect_beat("dc6", 12'd0, 6'd0, 1'b0);
    for (int i = 0; i < 3; i++) send(8'hF0, 11'd0, 2'd0);
    send(8'hA1, 11'd1, 2'd0);   expect_beat("ac_r10", 12'd1, 6'd10, 1'b0);
    send(8'h51, 11'd1, 2'd0);   expect_err("ovf");
    send(8'h00, 11'd0, 2'd0);   expect_beat("eob5", 12'd0, 6'd3, 1'b1);
    send(8'h30, 11'd0, 2'd0);   // DC of next block (value 0)
    send(8'h30, 11'd0, 2'd0);   expect_err("ac_r3s0");
    send(8'h00, 11'd0, 2'd0);   expect_beat("eob6", 12'd0, 6'd62, 1'b1);
    send(8'h0C, 11'd0, 2'd0);   expect_err("dc_s12");
    send(8'h01, 11'd1, 2'd3);   expect_err("dc_comp3");
    pulse_restart(1'b0);
    check_eq("rs2.err", 32'(error_out), 32'd0);

    // Interleaved components keep independent predictors
    send(8'h04, 11'b1010, 2'd1); expect_beat("c1a", 12'd10, 6'd0, 1'b0);
    send(8'h00, 11'd0, 2'd0);
    send(8'h03, 11'b011, 2'd2);  expect_beat("c2a", 12'hFFC, 6'd0, 1'b0);
    send(8'h00, 11'd0, 2'd0);
    send(8'h02, 11'b11, 2'd0);   expect_beat("c0a", 12'd3, 6'd0, 1'b0);
    send(8'h00, 11'd0, 2'd0);
    send(8'h01, 11'd1, 2'd1);    expect_beat("c1b", 12'd11, 6'd0, 1'b0);
    send(8'h00, 11'd0, 2'd0);
    send(8'h00, 11'd0, 2'd2);    expect_beat("c2b", 12'hFFC, 6'd0, 1'b0);
    send(8'h00, 11'd0, 2'd0);
    send(8'h0B, 11'h400, 2'd0);  expect_beat("c0_s11", 12'd1027, 6'd0, 1'b0);

    // Asynchronous reset mid-block clears outputs without a clock edge
    send(8'h11, 11'd0, 2'd0);    expect_beat("pre_rst", 12'hFFF, 6'd1, 1'b0);
    rst_in = 1'b1; #1;
    check_eq("mrst.valid", 32'(valid_out), 32'd0);
    check_eq("mrst.value", 32'(value_out), 32'd0);
    check_eq("mrst.run",   32'(run_out),   32'd0);
    check_eq("mrst.done",  32'(block_done_out), 32'd0);
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    send(8'h00, 11'd0, 2'd1);    expect_beat("post_rst_dc", 12'd0, 6'd0, 1'b0);
    send(8'h00, 11'd0, 2'd0);    expect_beat("post_rst_eob", 12'd0, 6'd62, 1'b1);
    send(8'h00, 11'd0, 2'd0);    expect_beat("post_rst_c0", 12'd0, 6'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rle_coeff_decoder.md
RLE_COEFF_DECODER -- requirements
Module: rle_coeff_decoder

Interface
REQ-001 SHALL have a single clock and an asynchronous, active-high reset, with ports named as follows.
- clk_in, input, 1 bit: clock.
- rst_in, input, 1 bit: asynchronous active-high reset.
REQ-002 SHALL have these symbol-input ports.
- symbol_in, input, 8 bits: Huffman-decoded symbol; [7:4] is RRRR (run), [3:0] is SSSS (size).
- amp_in, input, 11 bits: raw amplitude bits, right-justified in the low SSSS bits; upper bits are don't-care.
- comp_in, input, 2 bits: component index (0..2); sampled on DC symbols only.
- valid_in, input, 1 bit: symbol_in, amp_in and comp_in are valid this cycle.
- restart_in, input, 1 bit: restart-marker pulse.
REQ-003 SHALL have these coefficient-output ports.
- value_out, output, 12 bits: signed coefficient value; feeds the zigzag decoder value input.
- run_out, output, 6 bits: zeros to skip before value_out; feeds the zigzag decoder run input.
- valid_out, output, 1 bit: value_out and run_out are valid.
REQ-004 SHALL have these status ports.
- block_done_out, output, 1 bit: one-cycle pulse when the 64th coefficient position is emitted.
- error_out, output, 1 bit: sticky illegal-symbol flag.

Function
REQ-005 SHALL use two states, EXPECT_DC and EXPECT_AC, plus a 7-bit position counter pos (0..64) and three 12-bit DC predictors pred[0..2].
REQ-006 SHALL register all outputs, so a symbol accepted on cycle N produces outputs on cycle N+1.
REQ-007 SHALL not apply backpressure: every legal symbol produces exactly one valid_out beat.
REQ-008 SHALL compute the amplitude as ext = 0 when SSSS=0.
REQ-009 For SSSS>0, ext SHALL be amp[SSSS-1:0] when bit SSSS-1 is 1.
REQ-010 For SSSS>0 with bit SSSS-1 equal to 0, ext SHALL be amp[SSSS-1:0] - (2^SSSS - 1).
REQ-011 In EXPECT_DC, a DC symbol SHALL output value_out = pred[comp_in] + ext (12-bit two's-complement wrap) and run_out = 0.
REQ-012 A DC symbol SHALL write the sum back to pred[comp_in], set pos = 1 and move to EXPECT_AC.
REQ-013 In EXPECT_AC, a regular symbol (SSSS 1..10) SHALL output value_out = ext and run_out = RRRR, then set pos = pos + RRRR + 1.
REQ-014 ZRL (0xF0) SHALL output value_out = 0 and run_out = 15, then set pos = pos + 16.
REQ-015 EOB (0x00) SHALL output value_out = 0 and run_out = 63 - pos, then set pos = 64.
REQ-016 When the new pos equals 64, the block SHALL assert block_done_out together with that valid_out beat, clear pos to 0 and return to EXPECT_DC.
REQ-017 The following symbols SHALL be illegal: DC SSSS > 11; AC SSSS > 10; AC RRRR≠0 or 15 with SSSS=0; pos + run + 1 > 64; comp_in = 3 on a DC symbol.
REQ-018 An illegal symbol SHALL produce no valid_out, SHALL set error_out, and SHALL leave pos, state and predictors unchanged.
REQ-019 restart_in SHALL clear all predictors, pos and state (to EXPECT_DC) and SHALL clear error_out.
REQ-020 restart_in SHALL win over a simultaneous valid_in; that symbol is dropped with no output.
REQ-021 A restart mid-block SHALL abandon the partial block without asserting block_done_out.
REQ-022 The state and pos rules SHALL guarantee that the downstream write position sums to exactly 64 per block, so the zigzag decoder swaps buffers on the block_done_out beat.

Reset
REQ-023 Asserting rst_in SHALL immediately clear valid_out, block_done_out, error_out, value_out, run_out, pos and pred[0..2], and set the state to EXPECT_DC.
REQ-024 All registers SHALL use asynchronous assertion with deassertion taken on clk_in.
REQ-025 Reset mid-block SHALL discard the partial block without asserting block_done_out.

Verification
REQ-026 DC path: comp_in=0, symbol 0x03, amp 0b101 → value_out=5, run_out=0; second block DC 0x02 amp 0b01 → value_out=5-2=3.
REQ-027 Negative AC: symbol 0x23, amp 0b010 after DC → value_out=-5, run_out=2, pos becomes 4.
REQ-028 EOB: after DC and one AC 0x01 amp 1 (pos=2), symbol 0x00 → value_out=0, run_out=61, block_done_out=1, next symbol treated as DC.
REQ-029 Full block: DC then 63 × AC 0x01 → 64 valid_out beats, block_done_out only on the 64th; ZRL ×3 then 0x0F? → error_out, no output.
REQ-030 Overflow: pos=60, symbol 0x51 → error_out=1, no valid_out, pos stays 60; restart_in → error_out=0 and next DC uses predictor 0.
REQ-031 Predictor independence and reset: DC on comp 0, 1 and 2 interleaved keep separate predictors; rst_in asserted mid-block clears outputs within the same cycle.
